// File: rtl/axi_lite_dma_regs_if.sv
// axi_lite_dma_regs_if: AXI-Lite bus bundle between a host master and the DMA register slave
interface axi_lite_dma_regs_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  s_axi_lite_awvalid;
   logic                  s_axi_lite_awready;
   logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr;
   logic                  s_axi_lite_wvalid;
   logic                  s_axi_lite_wready;
   logic [DATA_WIDTH-1:0] s_axi_lite_wdata;
   logic [1:0]            s_axi_lite_bresp;
   logic                  s_axi_lite_bvalid;
   logic                  s_axi_lite_bready;
   logic                  s_axi_lite_arvalid;
   logic                  s_axi_lite_arready;
   logic [ADDR_WIDTH-1:0] s_axi_lite_araddr;
   logic                  s_axi_lite_rvalid;
   logic                  s_axi_lite_rready;
   logic [DATA_WIDTH-1:0] s_axi_lite_rdata;
   logic [1:0]            s_axi_lite_rresp;

   modport master (
      output s_axi_lite_awvalid, s_axi_lite_awaddr, s_axi_lite_wvalid, s_axi_lite_wdata,
             s_axi_lite_bready, s_axi_lite_arvalid, s_axi_lite_araddr, s_axi_lite_rready,
      input  s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
             s_axi_lite_arready, s_axi_lite_rvalid, s_axi_lite_rdata, s_axi_lite_rresp
   );

   modport slave (
      input  s_axi_lite_awvalid, s_axi_lite_awaddr, s_axi_lite_wvalid, s_axi_lite_wdata,
             s_axi_lite_bready, s_axi_lite_arvalid, s_axi_lite_araddr, s_axi_lite_rready,
      output s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_bresp, s_axi_lite_bvalid,
             s_axi_lite_arready, s_axi_lite_rvalid, s_axi_lite_rdata, s_axi_lite_rresp
   );
endinterface

// File: rtl/axi_lite_dma_regs.sv
// axi_lite_dma_regs: AXI-Lite control/status registers (CR, SR, ADDR, LENGTH) for a DMA channel
module axi_lite_dma_regs #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  axi_aclk,
   input  logic                  axi_areset,
   axi_lite_dma_regs_if.slave    axi,
   output logic [DATA_WIDTH-1:0] reg_cr,
   output logic [DATA_WIDTH-1:0] reg_addr,
   output logic [25:0]           reg_length,
   output logic                  start_pulse,
   input  logic                  done_set,
   output logic                  irq
);
   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   localparam logic [7:0] IDX_CR = 8'h00, IDX_SR = 8'h01, IDX_ADDR = 8'h06, IDX_LEN = 8'h0a;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   w_state_t              w_state;
   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
   logic [DATA_WIDTH-1:0] w_data_q, wr_data, sr_val, rd_mux;
   logic [7:0]            wr_idx, rd_idx;
   logic                  rs, ioc_en, ioc_irq;
   logic                  aw_hs, w_hs, ar_hs, wr_en, wr_hit, rd_hit;

   // The write commits on the edge that captures whichever of AW/W arrives last.
   always_comb begin
      aw_hs   = axi.s_axi_lite_awvalid & axi.s_axi_lite_awready;
      w_hs    = axi.s_axi_lite_wvalid & axi.s_axi_lite_wready;
      ar_hs   = axi.s_axi_lite_arvalid & axi.s_axi_lite_arready;
      wr_en   = ((w_state == W_IDLE) & aw_hs & w_hs) | ((w_state == W_HAVE_AW) & w_hs) |
                ((w_state == W_HAVE_W) & aw_hs);
      wr_addr = (w_state == W_HAVE_AW) ? aw_addr_q : axi.s_axi_lite_awaddr;
      wr_data = (w_state == W_HAVE_W) ? w_data_q : axi.s_axi_lite_wdata;
      wr_idx  = 8'(wr_addr >> 2);
      rd_idx  = 8'(axi.s_axi_lite_araddr >> 2);
      wr_hit  = wr_idx inside {IDX_CR, IDX_SR, IDX_ADDR, IDX_LEN};
      rd_hit  = rd_idx inside {IDX_CR, IDX_SR, IDX_ADDR, IDX_LEN};
      reg_cr  = DATA_WIDTH'({ioc_en, 11'b0, rs});
      sr_val  = DATA_WIDTH'({ioc_irq, 11'b0, ~rs});
      rd_mux  = (rd_idx == IDX_CR) ? reg_cr : (rd_idx == IDX_SR) ? sr_val :
                (rd_idx == IDX_ADDR) ? reg_addr : (rd_idx == IDX_LEN) ? DATA_WIDTH'(reg_length) : '0;
      irq     = ioc_irq & ioc_en;
   end

   always_ff @(posedge axi_aclk or posedge axi_areset)
      if (axi_areset) begin
         w_state                <= W_IDLE;
         axi.s_axi_lite_awready <= 1'b0;
         axi.s_axi_lite_wready  <= 1'b0;
         axi.s_axi_lite_bvalid  <= 1'b0;
         axi.s_axi_lite_bresp   <= OKAY;
         aw_addr_q              <= '0;
         w_data_q               <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= axi.s_axi_lite_awaddr;
         if (w_hs) w_data_q <= axi.s_axi_lite_wdata;
         if (wr_en) begin
            axi.s_axi_lite_bvalid <= 1'b1;
            axi.s_axi_lite_bresp  <= wr_hit ? OKAY : SLVERR;
         end else if (axi.s_axi_lite_bready) axi.s_axi_lite_bvalid <= 1'b0;
         case (w_state)
            W_IDLE: begin
               w_state                <= (aw_hs & w_hs) ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
               axi.s_axi_lite_awready <= ~aw_hs;
               axi.s_axi_lite_wready  <= ~w_hs;
            end
            W_HAVE_AW: if (w_hs) begin
               w_state               <= W_RESP;
               axi.s_axi_lite_wready <= 1'b0;
            end
            W_HAVE_W: if (aw_hs) begin
               w_state                <= W_RESP;
               axi.s_axi_lite_awready <= 1'b0;
            end
            W_RESP: if (axi.s_axi_lite_bready) begin
               w_state                <= W_IDLE;
               axi.s_axi_lite_awready <= 1'b1;
               axi.s_axi_lite_wready  <= 1'b1;
            end
         endcase
      end

   // done_set beats a same-cycle W1C so a completion is never lost.
   always_ff @(posedge axi_aclk or posedge axi_areset)
      if (axi_areset) begin
         rs          <= 1'b0;
         ioc_en      <= 1'b0;
         ioc_irq     <= 1'b0;
         reg_addr    <= '0;
         reg_length  <= '0;
         start_pulse <= 1'b0;
      end else begin
         start_pulse <= wr_en & (wr_idx == IDX_LEN) & rs;
         ioc_irq     <= done_set | (ioc_irq & ~(wr_en & (wr_idx == IDX_SR) & wr_data[12]));
         if (wr_en & (wr_idx == IDX_CR)) begin
            rs     <= wr_data[0];
            ioc_en <= wr_data[12];
         end
         if (wr_en & (wr_idx == IDX_ADDR)) reg_addr <= wr_data;
         if (wr_en & (wr_idx == IDX_LEN)) reg_length <= wr_data[25:0];
      end

   always_ff @(posedge axi_aclk or posedge axi_areset)
      if (axi_areset) begin
         r_state                <= R_IDLE;
         axi.s_axi_lite_arready <= 1'b0;
         axi.s_axi_lite_rvalid  <= 1'b0;
         axi.s_axi_lite_rdata   <= '0;
         axi.s_axi_lite_rresp   <= OKAY;
      end else
         case (r_state)
            R_IDLE: if (ar_hs) begin
               r_state                <= R_DATA;
               axi.s_axi_lite_arready <= 1'b0;
               axi.s_axi_lite_rvalid  <= 1'b1;
               axi.s_axi_lite_rdata   <= rd_mux;
               axi.s_axi_lite_rresp   <= rd_hit ? OKAY : SLVERR;
            end else axi.s_axi_lite_arready <= 1'b1;
            R_DATA: if (axi.s_axi_lite_rready) begin
               r_state                <= R_IDLE;
               axi.s_axi_lite_rvalid  <= 1'b0;
               axi.s_axi_lite_arready <= 1'b1;
            end
         endcase
endmodule

// File: tb/tb_axi_lite_dma_regs.sv
// tb_axi_lite_dma_regs: randomized scoreboard bench for the DMA register block
module tb_axi_lite_dma_regs;
   logic        axi_aclk = 1'b0, axi_areset = 1'b1, done_set = 1'b0;
   logic [31:0] reg_cr, reg_addr;
   logic [25:0] reg_length;
   logic        start_pulse, irq;

   axi_lite_dma_regs_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

   axi_lite_dma_regs #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset), .axi(bus),
      .reg_cr(reg_cr), .reg_addr(reg_addr), .reg_length(reg_length),
      .start_pulse(start_pulse), .done_set(done_set), .irq(irq)
   );

   always #5 axi_aclk = ~axi_aclk;

   int          errors = 0, checks = 0;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];
   logic        m_rs, m_ien, m_ioc;
   logic [31:0] m_addr;
   logic [25:0] m_len;
   logic [9:0]  amap [4] = '{10'h000, 10'h004, 10'h018, 10'h028};

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register-level reference model of the programmer's view.
   function automatic bit m_mapped(input logic [9:0] a);
      return a[9:2] inside {8'd0, 8'd1, 8'd6, 8'd10};
   endfunction

   function automatic logic [33:0] m_read(input logic [9:0] a);
      case (a[9:2])
         8'd0:    return {2'b00, 19'd0, m_ien, 11'd0, m_rs};
         8'd1:    return {2'b00, 19'd0, m_ioc, 11'd0, ~m_rs};
         8'd6:    return {2'b00, m_addr};
         8'd10:   return {2'b00, 6'd0, m_len};
         default: return {2'b10, 32'd0};
      endcase
   endfunction

   function automatic void m_write(input logic [9:0] a, input logic [31:0] d);
      case (a[9:2])
         8'd0:    begin m_rs = d[0]; m_ien = d[12]; end
         8'd1:    if (d[12]) m_ioc = 1'b0;
         8'd6:    m_addr = d;
         8'd10:   m_len = d[25:0];
         default: ;
      endcase
   endfunction

   always @(negedge axi_aclk) begin
      #1;
      if (bus.s_axi_lite_bvalid && bus.s_axi_lite_bready) begin
         chk("b_expected", 34'(bq.size() > 0), 34'd1);
         if (bq.size() > 0) chk("bresp", 34'(bus.s_axi_lite_bresp), 34'(bq.pop_front()));
      end
      if (bus.s_axi_lite_rvalid && bus.s_axi_lite_rready) begin
         chk("r_expected", 34'(rq.size() > 0), 34'd1);
         if (rq.size() > 0) chk("rresp_rdata", {bus.s_axi_lite_rresp, bus.s_axi_lite_rdata}, rq.pop_front());
      end
   end

   task automatic do_reset();
      axi_areset = 1'b1;
      {bus.s_axi_lite_awvalid, bus.s_axi_lite_wvalid, bus.s_axi_lite_bready} = '0;
      {bus.s_axi_lite_arvalid, bus.s_axi_lite_rready, done_set} = '0;
      bus.s_axi_lite_awaddr = '0; bus.s_axi_lite_araddr = '0; bus.s_axi_lite_wdata = '0;
      bq.delete(); rq.delete();
      {m_rs, m_ien, m_ioc, m_addr, m_len} = '0;
      repeat (3) @(negedge axi_aclk);
      chk("rst_readies", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_arready}, 34'd0);
      chk("rst_valids", {bus.s_axi_lite_bvalid, bus.s_axi_lite_rvalid, start_pulse, irq}, 34'd0);
      chk("rst_reg_cr", reg_cr, 34'd0);
      chk("rst_reg_addr", reg_addr, 34'd0);
      chk("rst_reg_length", reg_length, 34'd0);
      axi_areset = 1'b0;
      @(negedge axi_aclk);
      chk("readies_after_release", {bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_arready}, 34'd7);
   endtask

   task automatic pulse_done();
      done_set = 1'b1;
      @(negedge axi_aclk);
      done_set = 1'b0;
      m_ioc = 1'b1;
      chk("irq_after_done", irq, 34'(m_ien));
   endtask

   task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                            input int b_dly, input bit with_done = 0, input bit abort = 0);
      logic [1:0] exp_b;
      logic       exp_pulse;
      exp_b = m_mapped(a) ? 2'b00 : 2'b10;
      bq.push_back(exp_b);
      fork
         begin
            repeat (aw_dly) @(negedge axi_aclk);
            bus.s_axi_lite_awvalid = 1'b1; bus.s_axi_lite_awaddr = a;
            for (int i = 0; i < 20 && !bus.s_axi_lite_awready; i++) @(negedge axi_aclk);
            chk("awready_seen", bus.s_axi_lite_awready, 34'd1);
            @(negedge axi_aclk);
            bus.s_axi_lite_awvalid = 1'b0;
         end
         begin
            repeat (w_dly) @(negedge axi_aclk);
            bus.s_axi_lite_wvalid = 1'b1; bus.s_axi_lite_wdata = d;
            for (int i = 0; i < 20 && !bus.s_axi_lite_wready; i++) @(negedge axi_aclk);
            chk("wready_seen", bus.s_axi_lite_wready, 34'd1);
            @(negedge axi_aclk);
            bus.s_axi_lite_wvalid = 1'b0;
         end
         if (with_done) begin
            done_set = 1'b1;
            @(negedge axi_aclk);
            done_set = 1'b0;
         end
      join
      chk("bvalid_after_hs", bus.s_axi_lite_bvalid, 34'd1);
      exp_pulse = m_rs && a[9:2] == 8'd10;
      m_write(a, d);
      if (with_done) m_ioc = 1'b1;
      chk("start_pulse", start_pulse, 34'(exp_pulse));
      chk("reg_cr", reg_cr, {21'd0, m_ien, 11'd0, m_rs});
      chk("reg_addr", reg_addr, 34'(m_addr));
      chk("reg_length", reg_length, 34'(m_len));
      chk("irq", irq, 34'(m_ioc & m_ien));
      if (abort) begin
         axi_areset = 1'b1;
         #1;
         chk("bvalid_async_clear", bus.s_axi_lite_bvalid, 34'd0);
      end else begin
         for (int i = 0; i < b_dly; i++) begin
            @(negedge axi_aclk);
            chk("bvalid_hold", {bus.s_axi_lite_bvalid, bus.s_axi_lite_bresp}, {31'd0, 1'b1, exp_b});
            chk("awready_low_in_resp", bus.s_axi_lite_awready, 34'd0);
         end
         bus.s_axi_lite_bready = 1'b1;
         @(negedge axi_aclk);
         bus.s_axi_lite_bready = 1'b0;
         chk("start_pulse_one_cycle", start_pulse, 34'd0);
      end
   endtask

   task automatic axi_read(input logic [9:0] a, input int ar_dly, input int r_dly);
      logic [33:0] exp_r;
      exp_r = m_read(a);
      rq.push_back(exp_r);
      repeat (ar_dly) @(negedge axi_aclk);
      bus.s_axi_lite_arvalid = 1'b1; bus.s_axi_lite_araddr = a;
      for (int i = 0; i < 20 && !bus.s_axi_lite_arready; i++) @(negedge axi_aclk);
      chk("arready_seen", bus.s_axi_lite_arready, 34'd1);
      @(negedge axi_aclk);
      bus.s_axi_lite_arvalid = 1'b0;
      chk("rvalid_after_ar", bus.s_axi_lite_rvalid, 34'd1);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge axi_aclk);
         chk("rdata_hold", {bus.s_axi_lite_rresp, bus.s_axi_lite_rdata}, exp_r);
         chk("rvalid_hold_arready_low", {bus.s_axi_lite_rvalid, bus.s_axi_lite_arready}, 34'd2);
      end
      bus.s_axi_lite_rready = 1'b1;
      @(negedge axi_aclk);
      bus.s_axi_lite_rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      do_reset();
      axi_write(10'h018, 32'h1234_5678, 0, 3, 0);
      axi_read(10'h018, 0, 0);
      axi_write(10'h000, 32'h0000_1001, 1, 0, 2);
      axi_write(10'h028, 32'h0000_0040, 0, 0, 0);
      axi_write(10'h000, 32'h0000_0000, 0, 2, 0);
      axi_write(10'h028, 32'h0000_0080, 2, 0, 1);
      axi_write(10'h000, 32'h0000_1001, 0, 0, 0);
      pulse_done();
      axi_read(10'h004, 0, 1);
      axi_write(10'h004, 32'h0000_1000, 0, 0, 0);
      pulse_done();
      axi_write(10'h004, 32'h0000_1000, 0, 0, 0, 1);
      axi_read(10'h004, 0, 0);
      axi_write(10'h3FC, 32'hDEAD_BEEF, 0, 1, 0);
      axi_read(10'h3FC, 1, 0);
      axi_write(10'h018, 32'hCAFE_F00D, 0, 0, 5);
      axi_read(10'h018, 0, 5);
      fork
         axi_write(10'h018, 32'h0BAD_CAFE, 0, 0, 1);
         axi_read(10'h018, 0, 0);
      join
      axi_read(10'h01B, 0, 0);
      for (int n = 0; n < 250; n++) begin
         logic [9:0]  a, a2;
         logic [31:0] d;
         int          op;
         op = $urandom_range(0, 9);
         a  = ($urandom_range(0, 4) == 0) ? 10'($urandom) : {amap[$urandom_range(0, 3)][9:2], 2'($urandom)};
         a2 = {amap[$urandom_range(0, 3)][9:2], 2'($urandom)};
         d  = $urandom;
         if (op < 4) axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else if (op == 4) axi_write(a, d, 0, 0, $urandom_range(0, 2), 1);
         else if (op == 5) pulse_done();
         else if (op == 6)
            fork
               axi_write(a, d, 0, 0, $urandom_range(0, 2));
               axi_read(a2, 0, $urandom_range(0, 2));
            join
         else axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      axi_write(10'h000, 32'h0000_1001, 0, 0, 0);
      axi_write(10'h028, 32'h0000_0123, 0, 0, 0, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) axi_read(amap[i], 0, 0);
      repeat (3) @(negedge axi_aclk);
      chk("b_queue_drained", 34'(bq.size()), 34'd0);
      chk("r_queue_drained", 34'(rq.size()), 34'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_lite_dma_regs.md
AXI_LITE_DMA_REGS -- requirements
Module: axi_lite_dma_regs

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, width of the AXI-Lite byte address.
REQ-002 Parameter DATA_WIDTH, default 32, width of the AXI-Lite data bus.
REQ-003 axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-004 axi_areset  in  1  asynchronous reset, active-high.
REQ-005 s_axi_lite_awvalid  in  1  write address valid.
REQ-006 s_axi_lite_awready  out  1  write address ready.
REQ-007 s_axi_lite_awaddr  in  ADDR_WIDTH  write byte address.
REQ-008 s_axi_lite_wvalid  in  1  write data valid.
REQ-009 s_axi_lite_wready  out  1  write data ready.
REQ-010 s_axi_lite_wdata  in  DATA_WIDTH  write data.
REQ-011 s_axi_lite_bresp  out  2  write response; OKAY=2'b00, SLVERR=2'b10.
REQ-012 s_axi_lite_bvalid  out  1  write response valid.
REQ-013 s_axi_lite_bready  in  1  write response ready.
REQ-014 s_axi_lite_arvalid  in  1  read address valid.
REQ-015 s_axi_lite_arready  out  1  read address ready.
REQ-016 s_axi_lite_araddr  in  ADDR_WIDTH  read byte address.
REQ-017 s_axi_lite_rvalid  out  1  read data valid.
REQ-018 s_axi_lite_rready  in  1  read data ready.
REQ-019 s_axi_lite_rdata  out  DATA_WIDTH  read data.
REQ-020 s_axi_lite_rresp  out  2  read response; OKAY / SLVERR.
REQ-021 reg_cr  out  DATA_WIDTH  current CR value to the DMA core.
REQ-022 reg_addr  out  DATA_WIDTH  current ADDR value.
REQ-023 reg_length  out  26  current LENGTH[25:0].
REQ-024 start_pulse  out  1  one-cycle transfer start strobe.
REQ-025 done_set  in  1  one-cycle transfer-complete strobe from the core.
REQ-026 irq  out  1  level interrupt.

Function
REQ-027 Register decode uses addr[9:2]; addr[1:0] ignored; map: CR 0x00, SR 0x04, ADDR 0x18, LENGTH 0x28.
REQ-028 CR: bit0 RS and bit12 IOC_IrqEn are RW, all other bits read 0 (write mask 0x0000_1001).
REQ-029 SR: bit0 Halted = ~RS (RO); bit12 IOC_Irq set by done_set, cleared by writing 1 (W1C); other bits read 0.
REQ-030 ADDR: full 32-bit RW; LENGTH: bits[25:0] RW, bits[31:26] read 0.
REQ-031 Write FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; AW and W accepted independently in any order or same cycle.
REQ-032 awready high only in W_IDLE or W_HAVE_W; wready high only in W_IDLE or W_HAVE_AW; each drops the cycle after its handshake.
REQ-033 Register update occurs on the edge the second of AW/W is captured; bvalid asserts that same edge (one cycle after the final handshake).
REQ-034 bvalid holds, with bresp stable, until bready; W_RESP -> W_IDLE on the bvalid&bready edge.
REQ-035 Unmapped write address: no register change, bresp=SLVERR.
REQ-036 Write to LENGTH with RS=1 pulses start_pulse for exactly one cycle, coincident with the register update; with RS=0, value stored, no pulse.
REQ-037 done_set and W1C of IOC_Irq in the same cycle: set wins, bit stays 1.
REQ-038 irq = IOC_Irq & IOC_IrqEn, registered-free combinational of register state.
REQ-039 Read FSM states R_IDLE, R_DATA; arready high only in R_IDLE; rvalid asserts one cycle after AR handshake, rdata/rresp registered and stable until rready.
REQ-040 Unmapped read address: rdata=0, rresp=SLVERR.
REQ-041 Read and write paths fully independent; a read captured on the same edge as a write update returns the pre-write value.

Reset
REQ-042 While axi_areset=1: all registers 0, all outputs 0 (awready, wready, arready, bvalid, rvalid, start_pulse, irq), FSMs in IDLE.
REQ-043 awready, wready, arready rise on the first axi_aclk edge after reset release.
REQ-044 Reset mid-transaction discards captured address/data and any pending response; no register is written.

Verification
REQ-045 AW then W 3 cycles later to 0x18 data 0x1234_5678 -> bvalid 1 cycle after W handshake, bresp=00, read 0x18 returns 0x1234_5678.
REQ-046 Write CR=0x0000_1001, then LENGTH=0x40 -> start_pulse high one cycle, reg_length=0x40; repeat with CR=0 -> no pulse.
REQ-047 done_set pulse with IOC_IrqEn=1 -> SR reads 0x0000_1000 (RS=1), irq=1; write SR=0x1000 -> irq=0; W1C coincident with done_set -> bit remains 1.
REQ-048 Write/read to 0x3FC -> bresp=10, rresp=10, rdata=0, no register changes.
REQ-049 bready/rready held low 5 cycles -> bvalid/rvalid and data stable, awready/arready low throughout.
REQ-050 Assert axi_areset with bvalid pending -> bvalid=0 immediately, all registers read 0 after release.
